// File: rtl/dt_pass_engine.sv
`default_nettype none
// ============================================================================
//  Module   : dt_pass_engine
//  Purpose  : Raster-scan chamfer-1 pass unit for the distance-transform
//             datapath. One pass, forward or backward, is run over the
//             interior of an image held in an asynchronous-read RAM. Each
//             object pixel is rewritten in place with the chamfer minimum
//             of its four causal neighbours.
//  Ports    : clk        rising-edge clock
//             reset      asynchronous active-low reset
//             start      1-cycle launch pulse, honoured only when idle
//             mode       0 = forward, 1 = backward (sampled with start)
//             busy       pass in progress
//             done       1-cycle pulse at the end of a pass
//             mem_addr   RAM address (read or write)
//             mem_we     RAM write enable
//             mem_wdata  RAM write data
//             mem_rdata  RAM read data, combinational from mem_addr
//             obj_cnt    object pixels updated by the current/last pass
//  Revision : 1.0  initial release
// ============================================================================
module dt_pass_engine #(
    parameter int W_LOG2 = 7,
    parameter int H_LOG2 = 7,
    parameter int PIX_W  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       mode,
    output logic                       busy,
    output logic                       done,
    output logic [W_LOG2+H_LOG2-1:0]   mem_addr,
    output logic                       mem_we,
    output logic [PIX_W-1:0]           mem_wdata,
    input  logic [PIX_W-1:0]           mem_rdata,
    output logic [W_LOG2+H_LOG2-1:0]   obj_cnt
);

    localparam int c_ADDR_W = W_LOG2 + H_LOG2;
    localparam int c_W      = 1 << W_LOG2;
    localparam int c_H      = 1 << H_LOG2;

    // Images narrower or shorter than 3 pixels have no interior at all.
    localparam bit c_HAS_INTERIOR = (c_W >= 3) && (c_H >= 3);

    localparam logic [W_LOG2-1:0]   c_COL_LO   = W_LOG2'(1);
    localparam logic [W_LOG2-1:0]   c_COL_HI   = W_LOG2'(c_W - 2);
    localparam logic [H_LOG2-1:0]   c_ROW_LO   = H_LOG2'(1);
    localparam logic [H_LOG2-1:0]   c_ROW_HI   = H_LOG2'(c_H - 2);
    localparam logic [c_ADDR_W-1:0] c_ROW_STEP = c_ADDR_W'(c_W);
    localparam logic [c_ADDR_W-1:0] c_ONE      = c_ADDR_W'(1);
    localparam logic [PIX_W-1:0]    c_INF      = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_LOAD  = 3'd2,
        S_WRITE = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_mode;
    logic [H_LOG2-1:0]   r_row;
    logic [W_LOG2-1:0]   r_col;
    logic [1:0]          r_k;
    logic [PIX_W-1:0]    r_centre;
    logic [PIX_W-1:0]    r_min;

    logic [c_ADDR_W-1:0] w_centre_addr;
    logic [H_LOG2-1:0]   w_next_row;
    logic [W_LOG2-1:0]   w_next_col;
    logic [c_ADDR_W-1:0] w_next_addr;
    logic                w_last;
    logic [1:0]          w_k_sel;
    logic [c_ADDR_W-1:0] w_nb_ofs;
    logic [c_ADDR_W-1:0] w_nb_addr;
    logic [PIX_W-1:0]    w_min4;
    logic [PIX_W-1:0]    w_m1;
    logic [PIX_W-1:0]    w_result;

    assign w_centre_addr = {r_row, r_col};
    assign w_next_addr   = {w_next_row, w_next_col};

    // The last pixel of a pass is the far corner of the interior in scan order.
    assign w_last = r_mode ? ((r_row == c_ROW_LO) && (r_col == c_COL_LO))
                           : ((r_row == c_ROW_HI) && (r_col == c_COL_HI));

    always_comb begin
        w_next_row = r_row;
        w_next_col = r_col;
        if (!r_mode) begin
            if (r_col == c_COL_HI) begin
                w_next_col = c_COL_LO;
                w_next_row = r_row + H_LOG2'(1);
            end else begin
                w_next_col = r_col + W_LOG2'(1);
            end
        end else begin
            if (r_col == c_COL_LO) begin
                w_next_col = c_COL_HI;
                w_next_row = r_row - H_LOG2'(1);
            end else begin
                w_next_col = r_col - W_LOG2'(1);
            end
        end
    end

    // Address of the neighbour to present next: k=0 from CHECK, k+1 from LOAD.
    // Both directions share offset magnitudes W+1, W, W-1, 1; forward
    // subtracts them (causal = above/left), backward adds them.
    assign w_k_sel = (r_state == S_LOAD) ? (r_k + 2'd1) : 2'd0;

    always_comb begin
        w_nb_ofs = c_ONE;
        case (w_k_sel)
            2'd0:    w_nb_ofs = c_ROW_STEP + c_ONE;
            2'd1:    w_nb_ofs = c_ROW_STEP;
            2'd2:    w_nb_ofs = c_ROW_STEP - c_ONE;
            default: w_nb_ofs = c_ONE;
        endcase
    end

    assign w_nb_addr = r_mode ? (w_centre_addr + w_nb_ofs)
                              : (w_centre_addr - w_nb_ofs);

    // Final neighbour arrives on mem_rdata in the last LOAD cycle and is
    // folded into the running minimum here rather than being registered first.
    assign w_min4   = (mem_rdata < r_min) ? mem_rdata : r_min;
    assign w_m1     = (w_min4 == c_INF) ? c_INF : (w_min4 + PIX_W'(1));
    assign w_result = (r_mode && (r_centre < w_m1)) ? r_centre : w_m1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_mode    <= 1'b0;
            r_row     <= '0;
            r_col     <= '0;
            r_k       <= '0;
            r_centre  <= '0;
            r_min     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            obj_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode  <= mode;
                        obj_cnt <= '0;
                        busy    <= 1'b1;
                        if (c_HAS_INTERIOR) begin
                            if (mode) begin
                                r_row    <= c_ROW_HI;
                                r_col    <= c_COL_HI;
                                mem_addr <= {c_ROW_HI, c_COL_HI};
                            end else begin
                                r_row    <= c_ROW_LO;
                                r_col    <= c_COL_LO;
                                mem_addr <= {c_ROW_LO, c_COL_LO};
                            end
                            r_state <= S_CHECK;
                        end else begin
                            mem_addr <= '0;
                            r_state  <= S_FIN;
                        end
                    end
                end

                S_CHECK: begin
                    r_centre <= mem_rdata;
                    if (mem_rdata == '0) begin
                        // Background pixel: one cycle, no write.
                        if (w_last) begin
                            mem_addr <= '0;
                            r_state  <= S_FIN;
                        end else begin
                            r_row    <= w_next_row;
                            r_col    <= w_next_col;
                            mem_addr <= w_next_addr;
                        end
                    end else begin
                        r_k      <= 2'd0;
                        mem_addr <= w_nb_addr;
                        r_state  <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    r_min <= (r_k == 2'd0) ? mem_rdata : w_min4;
                    if (r_k == 2'd3) begin
                        mem_addr  <= w_centre_addr;
                        mem_we    <= 1'b1;
                        mem_wdata <= w_result;
                        r_state   <= S_WRITE;
                    end else begin
                        r_k      <= r_k + 2'd1;
                        mem_addr <= w_nb_addr;
                    end
                end

                S_WRITE: begin
                    mem_we  <= 1'b0;
                    obj_cnt <= obj_cnt + c_ONE;
                    if (w_last) begin
                        mem_addr <= '0;
                        r_state  <= S_FIN;
                    end else begin
                        r_row    <= w_next_row;
                        r_col    <= w_next_col;
                        mem_addr <= w_next_addr;
                        r_state  <= S_CHECK;
                    end
                end

                S_FIN: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
